// File: rtl/song_reader.sv
// Song sequencer: walks the song ROM at {song, note_index} and hands each note
// to the note player with a new_note/note_done handshake.
module song_reader #(
  parameter int NOTE_IDX_W = 5,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      reset_player,
  input  logic [1:0]                song,
  input  logic                      note_done,
  output logic [NOTE_IDX_W+1:0]     rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic                      new_note,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      song_done
);

  localparam logic [NOTE_IDX_W-1:0] IDX_ONE  = 1;
  localparam logic [NOTE_IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_ISSUE,
    S_WAIT_DONE,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [NOTE_IDX_W-1:0]   idx_q;
  logic [1:0]              song_q;
  logic                    new_note_q;
  logic                    song_done_q;
  logic [NOTE_W-1:0]       note_q;
  logic [DUR_W-1:0]        dur_q;

  logic [NOTE_W-1:0]       rom_note;
  logic [DUR_W-1:0]        rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      song_q      <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      note_q      <= '0;
      dur_q       <= '0;
    end else begin
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      // Song select tracks the mcu only while parked at the start of a song.
      if (state_q == S_IDLE && idx_q == '0)
        song_q <= song;
      if (reset_player) begin
        state_q <= S_IDLE;
        idx_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (play)
              state_q <= S_FETCH;
          end
          S_FETCH: begin
            state_q <= S_WAIT_ROM;
          end
          S_WAIT_ROM: begin
            if (rom_dur == '0) begin
              state_q     <= S_DONE;
              song_done_q <= 1'b1;
            end else begin
              note_q  <= rom_note;
              dur_q   <= rom_dur;
              state_q <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            new_note_q <= 1'b1;
            state_q    <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (note_done) begin
              if (idx_q == IDX_LAST) begin
                state_q     <= S_DONE;
                song_done_q <= 1'b1;
              end else begin
                idx_q   <= idx_q + IDX_ONE;
                state_q <= play ? S_FETCH : S_IDLE;
              end
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rom_addr  = {song_q, idx_q};
  assign new_note  = new_note_q;
  assign song_done = song_done_q;
  assign note      = note_q;
  assign duration  = dur_q;

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: directed corner cases plus table-driven
// randomized songs checked against a note-sequence model built from the ROM.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic        reset_player;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        song_done;

  logic [11:0] rom [128];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int s;
    int end_idx;
    int exp_notes;
    int exp_addr;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  song_reader #(
    .NOTE_IDX_W(5),
    .NOTE_W(6),
    .DUR_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .play(play),
    .reset_player(reset_player),
    .song(song),
    .note_done(note_done),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .new_note(new_note),
    .note(note),
    .duration(duration),
    .song_done(song_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Song s: random nonzero durations, end marker at end_idx (32 = none).
  task automatic fill_song(input int s, input int end_idx);
    for (int i = 0; i < 32; i++) begin
      if (i == end_idx)
        rom[7'(s*32+i)] = {6'($urandom_range(0, 63)), 6'd0};
      else
        rom[7'(s*32+i)] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
    end
  endtask

  task automatic restart(input int s);
    play         = 1'b0;
    note_done    = 1'b0;
    reset_player = 1'b1;
    song         = 2'(s);
    step();
    step();
    reset_player = 1'b0;
    step();
  endtask

  // Steps until new_note is seen; cyc = steps taken, 0 on timeout.
  task automatic wait_nn(input int max, output int cyc);
    int n;
    n   = 0;
    cyc = 0;
    while (cyc == 0 && n < max) begin
      step();
      n++;
      if (new_note) cyc = n;
    end
  endtask

  task automatic run_random(input int s, output int nn, output int sd);
    int exp_q[$];
    int pending, nd, cyc, drain, live;
    live = 1;
    for (int i = 0; i < 32; i++) begin
      if (live != 0 && rom[7'(s*32+i)][5:0] == 6'd0) live = 0;
      if (live != 0) exp_q.push_back(int'(rom[7'(s*32+i)]));
    end
    nn = 0; sd = 0; pending = 0; drain = 0; cyc = 0;
    while (drain < 8 && cyc < 4000) begin
      play      = ($urandom_range(0, 3) != 0);
      nd        = (pending != 0) ? int'($urandom_range(0, 2) == 0)
                                 : int'($urandom_range(0, 7) == 0);
      note_done = (nd != 0);
      step();
      cyc++;
      if (pending != 0 && nd != 0) pending = 0;
      if (new_note) begin
        if (nn < exp_q.size()) begin
          check("rnd_note", int'(note), exp_q[nn] >> 6);
          check("rnd_duration", int'(duration), exp_q[nn] & 63);
        end else begin
          check("rnd_extra_new_note", nn + 1, exp_q.size());
        end
        nn++;
        pending = 1;
      end
      if (song_done) sd++;
      if (sd > 0) drain++;
    end
    note_done = 1'b0;
    play      = 1'b0;
    check("rnd_model_note_count", nn, exp_q.size());
  endtask

  initial begin
    int c, nn, sd;

    vecs[0] = '{s: 0, end_idx: 1,  exp_notes: 1,  exp_addr: 'h01};
    vecs[1] = '{s: 1, end_idx: 3,  exp_notes: 3,  exp_addr: 'h23};
    vecs[2] = '{s: 2, end_idx: 0,  exp_notes: 0,  exp_addr: 'h40};
    vecs[3] = '{s: 3, end_idx: 32, exp_notes: 32, exp_addr: 'h7F};
    vecs[4] = '{s: 1, end_idx: 31, exp_notes: 31, exp_addr: 'h3F};

    for (int s = 0; s < 4; s++) fill_song(s, 32);

    // Reset state
    reset = 1'b0; play = 1'b0; reset_player = 1'b0; song = 2'd0; note_done = 1'b0;
    step();
    step();
    check("rst_new_note", int'(new_note), 0);
    check("rst_song_done", int'(song_done), 0);
    check("rst_note", int'(note), 0);
    check("rst_duration", int'(duration), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    reset = 1'b1;
    nn = 0; sd = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (new_note) nn++;
      if (song_done) sd++;
    end
    check("idle_no_new_note", nn, 0);
    check("idle_no_song_done", sd, 0);
    check("idle_rom_addr", int'(rom_addr), 0);

    // Two-word song 2: one note then end marker
    rom[7'h40] = {6'd10, 6'd3};
    rom[7'h41] = {6'd12, 6'd0};
    restart(2);
    play = 1'b1;
    wait_nn(10, c);
    check("s2_play_latency", c, 4);
    check("s2_note", int'(note), 10);
    check("s2_duration", int'(duration), 3);
    check("s2_rom_addr", int'(rom_addr), 'h40);
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    check("s2_rom_addr_after_done", int'(rom_addr), 'h41);
    nn = 0; sd = 0;
    for (int i = 0; i < 20; i++) begin
      play = ~play;
      note_done = (i % 3 == 0);
      step();
      if (new_note) nn++;
      if (song_done) sd++;
    end
    note_done = 1'b0;
    check("s2_song_done_once", sd, 1);
    check("s2_no_second_note", nn, 0);
    check("s2_note_held", int'(note), 10);
    check("s2_duration_held", int'(duration), 3);

    // Pause mid-song on song 1
    fill_song(1, 4);
    restart(1);
    play = 1'b1;
    wait_nn(10, c);
    check("pause_first_latency", c, 4);
    play = 1'b0;
    step();
    step();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    check("pause_index_advanced", int'(rom_addr), 'h21);
    nn = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (new_note) nn++;
    end
    check("pause_no_new_note", nn, 0);
    check("pause_rom_addr_frozen", int'(rom_addr), 'h21);
    play = 1'b1;
    wait_nn(10, c);
    check("resume_latency", c, 4);
    check("resume_note", int'(note), int'(rom[7'h21][11:6]));
    check("resume_duration", int'(duration), int'(rom[7'h21][5:0]));

    // Full 32-note song 0
    fill_song(0, 32);
    restart(0);
    play = 1'b1;
    sd = 0;
    for (int i = 0; i < 32; i++) begin
      wait_nn(10, c);
      check("full_latency", c, (i == 0) ? 4 : 3);
      check("full_note", int'(note), int'(rom[7'(i)][11:6]));
      check("full_duration", int'(duration), int'(rom[7'(i)][5:0]));
      note_done = 1'b1;
      step();
      note_done = 1'b0;
      if (song_done) sd++;
    end
    check("full_song_done", sd, 1);
    check("full_no_wrap_addr", int'(rom_addr), 'h1F);
    nn = 0; sd = 0;
    for (int i = 0; i < 10; i++) begin
      note_done = (i % 2 == 0);
      step();
      if (new_note) nn++;
      if (song_done) sd++;
    end
    note_done = 1'b0;
    check("full_no_extra_note", nn, 0);
    check("full_no_repeat_done", sd, 0);

    // reset_player coincident with note_done, then song change 1 -> 3
    fill_song(3, 5);
    restart(1);
    play = 1'b1;
    wait_nn(10, c);
    check("rp_latency", c, 4);
    note_done    = 1'b1;
    reset_player = 1'b1;
    play         = 1'b0;
    step();
    note_done = 1'b0;
    check("rp_index_zero", int'(rom_addr), 'h20);
    check("rp_no_song_done", int'(song_done), 0);
    song = 2'd3;
    step();
    reset_player = 1'b0;
    sd = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (song_done) sd++;
    end
    check("rp_no_song_done_after", sd, 0);
    play = 1'b1;
    step();
    check("rp_fetch_addr_song3", int'(rom_addr), 'h60);

    // Hard reset while the ROM word is pending
    step();
    reset = 1'b0;
    step();
    check("wr_rst_new_note", int'(new_note), 0);
    check("wr_rst_song_done", int'(song_done), 0);
    check("wr_rst_note", int'(note), 0);
    check("wr_rst_duration", int'(duration), 0);
    check("wr_rst_rom_addr", int'(rom_addr), 0);
    reset = 1'b1;
    play  = 1'b0;
    nn = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (new_note) nn++;
    end
    check("wr_rst_no_new_note", nn, 0);

    // Table-driven randomized songs
    for (int v = 0; v < 5; v++) begin
      fill_song(vecs[v].s, vecs[v].end_idx);
      restart(vecs[v].s);
      run_random(vecs[v].s, nn, sd);
      check("tbl_note_count", nn, vecs[v].exp_notes);
      check("tbl_song_done_once", sd, 1);
      check("tbl_final_rom_addr", int'(rom_addr), vecs[v].exp_addr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
